receptor_monedas: RTL and testbench



---
 rtl/receptor_monedas.sv | 208 ++++++++++++++++++++
 tb/tb_receptor_monedas.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/receptor_monedas.sv
// rtl/receptor_monedas.sv - coin-slot sensor conditioning, width classification and delivery to maquina_de_cafe
//
// Ports:
//   clk      in   system clock, all logic on posedge
//   rst      in   synchronous active-low reset
//   sensor   in   raw asynchronous coin-slot sensor, high while a coin passes
//   listo    in   machine ready to take a coin (sampled in ENTREGA)
//   hm       out  registered one-cycle "hay moneda" pulse
//   tm       out  coin type (0 chica, 1 grande), valid with hm, holds otherwise
//   rechazo  out  registered one-cycle pulse, coin returned
//   ocupado  out  high whenever the FSM is not idle
// Optional (macro RECEPTOR_CONTADORES_EN):
//   cuenta_ok   out [7:0]  saturating count of hm pulses
//   cuenta_rech out [7:0]  saturating count of rechazo pulses

module receptor_monedas #(
  parameter int DEB_CYC    = 4,
  parameter int MIN_CHICA  = 8,
  parameter int MAX_CHICA  = 15,
  parameter int MIN_GRANDE = 20,
  parameter int MAX_GRANDE = 40,
  parameter int ESPERA     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor,
  input  logic       listo,
  output logic       hm,
  output logic       tm,
  output logic       rechazo,
  output logic       ocupado
`ifdef RECEPTOR_CONTADORES_EN
  ,
  output logic [7:0] cuenta_ok,
  output logic [7:0] cuenta_rech
`endif
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int WW = $clog2(MAX_GRANDE + 2);
  localparam int EW = $clog2(ESPERA + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [WW-1:0] W_SAT    = WW'(MAX_GRANDE + 1);
  localparam logic [WW-1:0] W_MIN_C  = WW'(MIN_CHICA);
  localparam logic [WW-1:0] W_MAX_C  = WW'(MAX_CHICA);
  localparam logic [WW-1:0] W_MIN_G  = WW'(MIN_GRANDE);
  localparam logic [WW-1:0] W_MAX_G  = WW'(MAX_GRANDE);
  localparam logic [EW-1:0] E_MAX    = EW'(ESPERA);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MIDIENDO,
    S_ENTREGA,
    S_RECHAZO
  } estado_t;

  // ---------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------
  logic          s1, s2;
  logic          v1, v2;       // synchroniser holds real samples once v2 is set
  logic          f, f_d;
  logic [DW-1:0] deb_cnt;
  logic          armed;        // a genuine low level has been seen since reset
  logic          rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      f       <= 1'b0;
      f_d     <= 1'b0;
      deb_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      s1  <= sensor;
      s2  <= s1;
      v1  <= 1'b1;
      v2  <= v1;
      f_d <= f;
      // f only follows s2 after DEB_CYC consecutive disagreeing samples,
      // so both edges see the same delay and short glitches vanish.
      if (s2 != f) begin
        if (deb_cnt == DEB_LAST) begin
          f       <= s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
      // The reset value of f is not a real observation: a coin sitting in
      // the slot through reset must not look like a fresh arrival.
      if (v2 && !s2 && !f) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = f && !f_d && armed;

  // ---------------------------------------------------------------
  // Measurement / delivery FSM
  // ---------------------------------------------------------------
  estado_t       state_q, state_d;
  logic [WW-1:0] width_q, width_d;
  logic [EW-1:0] wait_q, wait_d;
  logic          tm_pend_q, tm_pend_d;
  logic          hm_d, tm_d, rechazo_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      width_q   <= '0;
      wait_q    <= '0;
      tm_pend_q <= 1'b0;
      hm        <= 1'b0;
      tm        <= 1'b0;
      rechazo   <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      wait_q    <= wait_d;
      tm_pend_q <= tm_pend_d;
      hm        <= hm_d;
      tm        <= tm_d;
      rechazo   <= rechazo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    wait_d    = wait_q;
    tm_pend_d = tm_pend_q;
    hm_d      = 1'b0;
    tm_d      = tm;
    rechazo_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          width_d = WW'(1);
          state_d = S_MIDIENDO;
        end
      end
      S_MIDIENDO: begin
        if (f) begin
          if (width_q != W_SAT) begin
            width_d = width_q + WW'(1);
          end
        end else if (width_q >= W_MIN_C && width_q <= W_MAX_C) begin
          tm_pend_d = 1'b0;
          wait_d    = '0;
          state_d   = S_ENTREGA;
        end else if (width_q >= W_MIN_G && width_q <= W_MAX_G) begin
          tm_pend_d = 1'b1;
          wait_d    = '0;
          state_d   = S_ENTREGA;
        end else begin
          rechazo_d = 1'b1;
          state_d   = S_RECHAZO;
        end
      end
      S_ENTREGA: begin
        // listo is checked before the timeout so a late ready still wins
        if (listo) begin
          hm_d    = 1'b1;
          tm_d    = tm_pend_q;
          state_d = S_IDLE;
        end else if (wait_q == E_MAX) begin
          rechazo_d = 1'b1;
          state_d   = S_RECHAZO;
        end else begin
          wait_d = wait_q + EW'(1);
        end
      end
      S_RECHAZO: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ocupado = (state_q != S_IDLE);

`ifdef RECEPTOR_CONTADORES_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cuenta_ok   <= 8'd0;
      cuenta_rech <= 8'd0;
    end else begin
      if (hm && cuenta_ok != 8'hFF) begin
        cuenta_ok <= cuenta_ok + 8'd1;
      end
      if (rechazo && cuenta_rech != 8'hFF) begin
        cuenta_rech <= cuenta_rech + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_receptor_monedas.sv
// tb/tb_receptor_monedas.sv - randomized self-checking bench for receptor_monedas

module tb_receptor_monedas;

  localparam int DEB_CYC    = 4;
  localparam int MIN_CHICA  = 8;
  localparam int MAX_CHICA  = 15;
  localparam int MIN_GRANDE = 20;
  localparam int MAX_GRANDE = 40;
  localparam int ESPERA     = 64;
  // raw rise to f rise: 2 sync flops + DEB_CYC samples; classify one cycle after f falls
  localparam int T_CLASIF   = 2 + DEB_CYC;

  logic clk = 1'b0;
  logic rst, sensor, listo;
  logic hm, tm, rechazo, ocupado;
`ifdef RECEPTOR_CONTADORES_EN
  logic [7:0] cuenta_ok, cuenta_rech;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_ok = 0;
  int exp_rech = 0;

  always #5 clk = ~clk;

  receptor_monedas dut (
    .clk        (clk),
    .rst        (rst),
    .sensor     (sensor),
    .listo      (listo),
    .hm         (hm),
    .tm         (tm),
    .rechazo    (rechazo),
    .ocupado    (ocupado)
`ifdef RECEPTOR_CONTADORES_EN
    ,
    .cuenta_ok  (cuenta_ok),
    .cuenta_rech(cuenta_rech)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outcome of one coin of raw width n, with listo raised d cycles into
  // the delivery window (d<0: listo always high).
  // kind: 0 nothing, 1 hm, 2 rechazo. at: bench cycle index of the pulse.
  function automatic void predict(input int n, input int d,
                                  output int kind, output int at, output int typ);
    int eff;
    bit ok;
    eff  = (d < 0) ? 0 : d;
    ok   = (n >= MIN_CHICA && n <= MAX_CHICA) || (n >= MIN_GRANDE && n <= MAX_GRANDE);
    typ  = (n >= MIN_GRANDE) ? 1 : 0;
    kind = 0;
    at   = -1;
    if (n < DEB_CYC) begin
      kind = 0;
    end else if (!ok) begin
      kind = 2;
      at   = n + T_CLASIF + 1;
    end else if (eff <= ESPERA) begin
      kind = 1;
      at   = n + T_CLASIF + 2 + eff;
    end else begin
      kind = 2;
      at   = n + T_CLASIF + 2 + ESPERA;
    end
  endfunction

  task automatic run_coin(input int n, input int d, input string tag);
    int kind, at, typ;
    int hm_cnt, re_cnt, hm_at, re_at, tm_seen, both, busy;
    hm_cnt = 0; re_cnt = 0; hm_at = -1; re_at = -1; tm_seen = 0; both = 0; busy = 0;
    predict(n, d, kind, at, typ);
    for (int c = 0; c < n + 95; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (hm === 1'b1) begin hm_cnt++; hm_at = c; tm_seen = int'(tm); end
        if (rechazo === 1'b1) begin re_cnt++; re_at = c; end
        if (hm === 1'b1 && rechazo === 1'b1) both++;
        if (ocupado === 1'b1) busy = 1;
      end
      sensor = (c < n);
      listo  = (d < 0) ? 1'b1 : (c >= n + T_CLASIF + 1 + d);
    end
    check({tag, "_hm_cnt"}, hm_cnt, (kind == 1) ? 1 : 0);
    check({tag, "_rech_cnt"}, re_cnt, (kind == 2) ? 1 : 0);
    check({tag, "_both"}, both, 0);
    check({tag, "_busy"}, busy, (n >= DEB_CYC) ? 1 : 0);
    check({tag, "_idle_end"}, ocupado, 0);
    if (kind == 1) begin
      check({tag, "_hm_at"}, hm_at, at);
      check({tag, "_tm"}, tm_seen, typ);
      if (exp_ok < 255) exp_ok++;
    end
    if (kind == 2) begin
      check({tag, "_rech_at"}, re_at, at);
      if (exp_rech < 255) exp_rech++;
    end
  endtask

  initial begin
    int pulses, busy, n, d;
    rst = 1'b0; sensor = 1'b1; listo = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hm", hm, 0);
    check("rst_tm", tm, 0);
    check("rst_rechazo", rechazo, 0);
    check("rst_ocupado", ocupado, 0);
`ifdef RECEPTOR_CONTADORES_EN
    check("rst_cuenta_ok", cuenta_ok, 0);
    check("rst_cuenta_rech", cuenta_rech, 0);
`endif

    // coin already present at reset release must not be measured
    rst = 1'b1;
    pulses = 0; busy = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (hm === 1'b1 || rechazo === 1'b1) pulses++;
        if (ocupado === 1'b1) busy = 1;
      end
      sensor = (c < 20);
    end
    check("post_rst_pulses", pulses, 0);
    check("post_rst_busy", busy, 0);

    run_coin(12, -1, "chica");
    run_coin(30, -1, "grande");
    run_coin(17, -1, "gap17");
    run_coin(2, -1, "glitch");
    run_coin(60, -1, "long60");
    run_coin(12, 200, "timeout");
    run_coin(12, 30, "listo30");
    run_coin(12, ESPERA, "listo_at_espera");
    run_coin(12, ESPERA + 1, "listo_late");
    run_coin(3, -1, "glitch3");
    run_coin(4, -1, "w4");
    run_coin(7, -1, "w7");
    run_coin(8, -1, "w8");
    run_coin(15, -1, "w15");
    run_coin(16, -1, "w16");
    run_coin(19, -1, "w19");
    run_coin(20, -1, "w20");
    run_coin(40, -1, "w40");
    run_coin(41, -1, "w41");

    // reset in the middle of a measurement
    pulses = 0; busy = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (hm === 1'b1 || rechazo === 1'b1) pulses++;
        if (c >= 14 && ocupado === 1'b1) busy = 1;
      end
      sensor = (c < 30);
      listo  = 1'b1;
      rst    = !(c == 12 || c == 13);
    end
    rst = 1'b1;
    check("midrst_pulses", pulses, 0);
    check("midrst_busy", busy, 0);
    exp_ok = 0;
    exp_rech = 0;
`ifdef RECEPTOR_CONTADORES_EN
    check("midrst_cuenta_ok", cuenta_ok, 0);
`endif

    run_coin(12, -1, "acc1");
    run_coin(30, -1, "acc2");
    run_coin(17, -1, "rej1");
`ifdef RECEPTOR_CONTADORES_EN
    check("cuenta_ok_2", cuenta_ok, 2);
    check("cuenta_rech_1", cuenta_rech, 1);
`endif

    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(1, 60);
      d = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 80);
      run_coin(n, d, $sformatf("rnd%0d_n%0d_d%0d", i, n, d));
    end

`ifdef RECEPTOR_CONTADORES_EN
    for (int i = 0; i < 300; i++) begin
      run_coin(10, -1, "sat");
    end
    check("cuenta_ok_sat", cuenta_ok, exp_ok);
    check("cuenta_rech_final", cuenta_rech, exp_rech);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
